quad_encoder_gen: RTL
=====================

Name: quad_encoder_gen

Overview:
- Quadrature signal generator: converts step commands into clean A/B quadrature waveforms. It is the transmit side of the encoder/debounce/decoder input path.
- Used as an on-chip self-test source and as a bench stimulus model driving the rotary-encoder input pins of the RGB mixer.
- Accepts a direction and step count over a valid/ready handshake, then emits one quadrature edge every STEP_DIV clocks.
- Tracks the net position it has emitted.

Parameters:
- STEP_DIV, 16, clocks between successive quadrature edges; legal range 4..65535.
- CNT_W, 8, width of the step-count field and of the position counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_dir  in  1  1 = up (A leads B), 0 = down (B leads A)
- cmd_steps  in  CNT_W  number of quadrature edges to emit
- enc_a  out  1  quadrature channel A
- enc_b  out  1  quadrature channel B
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes
- position  out  CNT_W  net edges emitted, wraps modulo 2^CNT_W

Behaviour:
- Reset (asynchronous assert, synchronous-release use):
  - enc_a=0, enc_b=0, phase=00, position=0.
  - busy=0, done=0, cmd_ready=1.
  - FSM goes to IDLE; timer and remaining count clear.
- Phase sequence as {A,B}:
  - Up: 00→10→11→01→00.
  - Down: exact reverse.
  - Exactly one line changes per edge.
- FSM states are IDLE, RUN, FIN.
- IDLE:
  - cmd_ready=1, busy=0.
  - A command is accepted on cmd_valid & cmd_ready.
  - If cmd_steps==0: go to FIN; no edge is emitted.
  - Otherwise: latch dir, set remaining=cmd_steps, set timer=STEP_DIV-1, go to RUN.
- RUN:
  - cmd_ready=0, busy=1; cmd_valid is ignored.
  - Timer decrements each cycle.
  - When the timer is 0:
    - Phase advances per the latched dir; enc_a/enc_b are registered and change on that edge.
    - position±1 (up=+1, down=−1, modulo wrap).
    - remaining decrements and the timer reloads to STEP_DIV-1.
  - After the edge that brings remaining to 0, go to FIN.
- FIN:
  - done=1 for exactly one cycle, busy=0, cmd_ready=0.
  - Next state is IDLE.
- Timing:
  - First edge appears STEP_DIV cycles after the acceptance cycle.
  - Edge spacing is exactly STEP_DIV clocks.
  - done asserts one cycle after the last edge.
  - Minimum gap between back-to-back commands is 2 cycles (FIN + IDLE accept).
- Phase continuity:
  - Phase is never reset between commands.
  - A direction reversal starts from the current phase; no jump or double edge.
- Wrap-around: position 2^CNT_W−1 plus up wraps to 0; 0 plus down wraps to 2^CNT_W−1.
- Reset mid-RUN: the command is aborted, no done pulse, outputs return to their reset values.
- Outputs enc_a and enc_b are driven directly from flops, with no combinational path from inputs.

Optional Feature:
- Macro QUAD_BOUNCE_EN.
- When defined, each edge carries a contact-bounce pattern on the changing line for debouncer testing:
  - Cycle 0: new value.
  - Cycle 1: old value.
  - Cycle 2: new value.
  - Cycle 3: old value.
  - Cycle 4 onward: new value, stable until the next edge.
  - position and done timing are unchanged.
  - STEP_DIV must be at least 8; the design fails elaboration otherwise.
- When undefined, edges are clean and STEP_DIV may be as low as 4.

Decomposition:
- Package quad_pkg holds:
  - FSM state enum (IDLE, RUN, FIN).
  - Phase encoding constants PH_00/PH_10/PH_11/PH_01.
  - Direction constants DIR_UP=1, DIR_DOWN=0.
  - Function next_phase(phase, dir).
- One sub-module, quad_step_timer: reloadable down-counter of width $clog2(STEP_DIV) that emits a tick when it reaches 0.
- FSM, phase register, bounce shaper and position counter stay in quad_encoder_gen.

Test Plan:
- After reset release, hold 3 cycles → enc_a=0, enc_b=0, position=0, cmd_ready=1, busy=0.
- STEP_DIV=16, cmd up 4 steps accepted at cycle T:
  - Edges at T+16, T+32, T+48, T+64.
  - {A,B} sequence 10, 11, 01, 00.
  - done pulse at T+65; position=4.
- From position=4, cmd down 6 steps:
  - {A,B} sequence 01, 11, 10, 00, 01, 11.
  - Final position=254 (CNT_W=8).
  - No edge is skipped or doubled at the reversal.
- Zero-step and busy handling:
  - cmd_steps=0 → no edge, done two cycles after acceptance.
  - cmd_valid held high during RUN → cmd_ready=0 and the second command is accepted only after FIN.
- Assert reset 10 cycles into a 20-step command → outputs immediately 00, position=0, no done pulse.
- With QUAD_BOUNCE_EN, STEP_DIV=16, one up step → A sequence 1,0,1,0,1 over cycles T+16..T+20, then stable at 1.
- Closed loop: generator drives the debounce + encoder path with 10 up steps → decoded count increases by the encoder's per-edge scaling.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature step generator.
package quad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Gray-code step of the {A,B} pair: up walks 00-10-11-01, down walks the reverse.
    function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
        logic [1:0] nxt;
        nxt = phase;
        case (phase)
            PH_00:   nxt = (dir == DIR_UP) ? PH_10 : PH_01;
            PH_10:   nxt = (dir == DIR_UP) ? PH_11 : PH_00;
            PH_11:   nxt = (dir == DIR_UP) ? PH_01 : PH_10;
            PH_01:   nxt = (dir == DIR_UP) ? PH_00 : PH_11;
            default: nxt = PH_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_encoder_gen_step_timer.sv
// Reloadable down-counter that paces quadrature edges; tick_c fires on the zero count.
module quad_step_timer #(
    parameter int unsigned STEP_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned TMR_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [TMR_W-1:0] RELOAD = TMR_W'(STEP_DIV - 1);

    logic [TMR_W-1:0] count_q;

    assign tick_c = en && (count_q == '0);

    // Load on command accept, otherwise count down and wrap to the reload value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= RELOAD;
        end else if (en) begin
            count_q <= (count_q == '0) ? RELOAD : (count_q - TMR_W'(1));
        end
    end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature signal generator: turns direction/step commands into A/B edges,
// one edge every STEP_DIV clocks, and tracks the net position emitted.
// Define QUAD_BOUNCE_EN to add a contact-bounce pattern after every edge.
module quad_encoder_gen
    import quad_pkg::*;
#(
    parameter int unsigned STEP_DIV = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_steps,
    output logic             enc_a,
    output logic             enc_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] position
);

    if (STEP_DIV < 4 || STEP_DIV > 65535) begin : g_bad_step_div
        $error("quad_encoder_gen: STEP_DIV must be within 4..65535");
    end

`ifdef QUAD_BOUNCE_EN
    if (STEP_DIV < 8) begin : g_bad_bounce_div
        $error("quad_encoder_gen: bounce shaping needs STEP_DIV >= 8");
    end
`endif

    state_t           state_q;
    state_t           state_n;
    logic             load_c;
    logic             tick_c;
    logic             ready_n;
    logic             busy_n;
    logic             done_n;
    logic             dir_q;
    logic [CNT_W-1:0] remaining_q;
    logic [1:0]       phase_q;
    logic [1:0]       phase_nxt_c;

    assign phase_nxt_c = next_phase(phase_q, dir_q);

    quad_step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load_c),
        .en     (state_q == RUN),
        .tick_c (tick_c)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state and the handshake/status values to register alongside it.
    always_comb begin
        state_n = state_q;
        load_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_steps == '0) begin
                        state_n = FIN;
                    end else begin
                        state_n = RUN;
                        load_c  = 1'b1;
                    end
                end
            end
            RUN: begin
                // Remaining hits zero on the final edge; leave the cycle after it.
                if (remaining_q == '0) begin
                    state_n = FIN;
                end
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == IDLE);
        busy_n  = (state_n == RUN);
        done_n  = (state_n == FIN);
    end

    // Registered status outputs, aligned with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cmd_ready <= ready_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // Latch the command and count down the edges still owed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q       <= DIR_UP;
            remaining_q <= '0;
        end else if (load_c) begin
            dir_q       <= cmd_dir;
            remaining_q <= cmd_steps;
        end else if (tick_c) begin
            remaining_q <= remaining_q - CNT_W'(1);
        end
    end

    // Clean phase and net position; phase carries over between commands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q  <= PH_00;
            position <= '0;
        end else if (tick_c) begin
            phase_q  <= phase_nxt_c;
            position <= (dir_q == DIR_UP) ? (position + CNT_W'(1)) : (position - CNT_W'(1));
        end
    end

`ifdef QUAD_BOUNCE_EN
    logic [2:0] bounce_q;
    logic [1:0] old_q;

    // Output shaper: new, old, new, old, then settle on new after each edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enc_a    <= 1'b0;
            enc_b    <= 1'b0;
            bounce_q <= 3'd0;
            old_q    <= PH_00;
        end else if (tick_c) begin
            {enc_a, enc_b} <= phase_nxt_c;
            old_q          <= phase_q;
            bounce_q       <= 3'd1;
        end else if (bounce_q != 3'd0) begin
            {enc_a, enc_b} <= bounce_q[0] ? old_q : phase_q;
            bounce_q       <= (bounce_q == 3'd4) ? 3'd0 : (bounce_q + 3'd1);
        end
    end
`else
    // Clean output: A/B flops follow the phase on each edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enc_a <= 1'b0;
            enc_b <= 1'b0;
        end else if (tick_c) begin
            {enc_a, enc_b} <= phase_nxt_c;
        end
    end
`endif

endmodule
